rename_stage: RTL and testbench
===============================

# rename_stage

Two-wide register rename stage that sits directly upstream of the reservation station. Each cycle it accepts up to one bundle of two decoded instructions with 5-bit architectural register numbers. It translates them through a register alias table (RAT), allocates 6-bit physical destinations from a free list, and presents the renamed bundle to the reservation station one cycle later. Physical registers released at commit are returned to the free list through two free ports.

## Interface
- NUM_PREGS, 64: physical registers; physical tag width is 6 bits.
- NUM_AREGS, 32: architectural registers; architectural index width is 5 bits.
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high.
- in_valid  in  1: decode bundle (slots 1 and 2) is valid.
- in_ready  out  1: stage can accept a bundle this cycle.
- rs1_1, rs2_1, rd_1  in  5 each: slot-1 architectural registers.
- imm_1  in  32; alu_op_1  in  3; opcode_1  in  7: slot-1 payload.
- rs1_2, rs2_2, rd_2, imm_2, alu_op_2, opcode_2  in: slot-2 equivalents, same widths.
- full  in  1: reservation station cannot take a bundle.
- out_valid  out  1: renamed bundle valid, one-cycle pulse per accepted bundle.
- rs1_o_1, rs2_o_1, rd_o_1  out  6 each: slot-1 physical tags.
- old_rd_o_1  out  6: previous mapping of rd_1, carried to the ROB and freed at commit.
- imm_o_1  out  32; alu_op_o_1  out  3; opcode_o_1  out  7: slot-1 payload passthrough.
- rs1_o_2, rs2_o_2, rd_o_2, old_rd_o_2, imm_o_2, alu_op_o_2, opcode_o_2  out: slot-2 equivalents.
- free_valid_1, free_valid_2  in  1 each: commit returns a physical register.
- free_preg_1, free_preg_2  in  6 each: returned tags.
- free_count  out  6: free-list occupancy, 0..32.

## Operation
- RAT: 32 entries × 6 bits. Reset value RAT[i] = i.
- Free list: circular FIFO, 32 entries × 6 bits, with 5-bit head and tail pointers that wrap modulo 32.
  - Reset contents: 32..63 in order.
  - Reset state: head = 0, tail = 0, count = 32.
- A slot writes a destination when its opcode is 0110011 (R-type), 0010011 (I-type) or 0000011 (load), and rd != 0.
  - Store (0100011), any other opcode, or rd = 0: no allocation.
  - For such slots, rd_o = 0 and old_rd_o = 0.
- in_ready = !full && (free_count >= 2). It does not depend on in_valid or the opcodes.
- Accept = in_valid && in_ready. On accept:
  - Slot-1 sources are read from the RAT.
  - A writing slot 1 pops the free-list head into rd_o_1. old_rd_o_1 = RAT[rd_1]. RAT[rd_1] is updated.
  - Slot-2 sources bypass slot 1: if slot 1 writes and rs1_2 or rs2_2 equals rd_1, the source uses slot 1's new tag. Otherwise it uses the RAT.
  - A writing slot 2 pops the next free entry: head+1 if slot 1 also pops, otherwise head.
  - old_rd_o_2 = slot 1's new tag when slot 1 writes and rd_2 == rd_1; otherwise RAT[rd_2].
  - When both slots write the same rd, the RAT ends holding slot 2's tag.
- Architectural source 0 always maps to physical 0. RAT[0] is never written.
- Free ports push at the tail: slot 1 first, then slot 2.
  - A free of tag 0 is ignored.
  - A push when count = 32 is dropped, and an error flag is raised for simulation assertions.
- Net count update in a cycle = pushes − pops. Simultaneous pushes and pops in the same cycle are legal.
- Freed tags become allocatable in the cycle after the push. No same-cycle bypass from the free ports to allocation.
- Payload fields (imm, alu_op, opcode) are registered unchanged.

## Timing
- Rename latency is 1 cycle: a bundle accepted at edge N appears on the outputs after edge N with out_valid = 1.
- Without an accept, out_valid = 0 the next cycle. The data outputs hold their last values.
- RAT, pointer and count updates land at the same edge as the accept.
- Reset (asserted asynchronously, including mid-operation):
  - out_valid = 0.
  - All data outputs = 0.
  - free_count = 32.
  - RAT and free list return to their reset values.
  - in_ready is 1 once reset is released, provided full = 0.
  - Any bundle in flight at reset is discarded.
- full rising at edge N blocks acceptance at edge N. The already-registered bundle still presents for one cycle; the reservation station absorbs it.

## Test plan
- Reset, then bundle {add x5 ← x1, x2 ; addi x6 ← x5}. Required next cycle:
  - rs1_o_1 = 1, rs2_o_1 = 2, rd_o_1 = 32, old_rd_o_1 = 5.
  - rs1_o_2 = 32, rd_o_2 = 33, old_rd_o_2 = 6.
  - free_count = 30.
- Bundle {sw x3 → x4 ; add x0 ← x1, x1}: no pops, free_count unchanged, rd_o_1 = rd_o_2 = 0.
- Both slots add to x7 after reset:
  - rd_o_1 = 32, rd_o_2 = 33, old_rd_o_2 = 32, old_rd_o_1 = 7.
  - A later read of x7 yields 33.
- Drain the free list with 16 two-write bundles: free_count = 0 and in_ready = 0.
  - Free p5 alone: count = 1 and in_ready stays 0.
  - Free p6 the next cycle: in_ready = 1 the following cycle.
  - The next two-write bundle receives tags 5 and 6.
- Hold full = 1 with in_valid = 1 for 3 cycles: in_ready = 0, out_valid = 0, RAT and count unchanged.
- Assert reset mid-stream with free_count = 20: outputs are 0 immediately. After release, an add x9 gets rd_o_1 = 32 and old_rd_o_1 = 9.

Source files
------------

// File: rtl/rename_stage.sv
// Two-wide register rename: RAT lookup with intra-bundle bypass, free-list
// allocation of destinations, and commit-side tag return through two free ports.
module rename_stage #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs1_1,
  input  logic [4:0]  rs2_1,
  input  logic [4:0]  rd_1,
  input  logic [31:0] imm_1,
  input  logic [2:0]  alu_op_1,
  input  logic [6:0]  opcode_1,
  input  logic [4:0]  rs1_2,
  input  logic [4:0]  rs2_2,
  input  logic [4:0]  rd_2,
  input  logic [31:0] imm_2,
  input  logic [2:0]  alu_op_2,
  input  logic [6:0]  opcode_2,
  input  logic        full,
  output logic        out_valid,
  output logic [5:0]  rs1_o_1,
  output logic [5:0]  rs2_o_1,
  output logic [5:0]  rd_o_1,
  output logic [5:0]  old_rd_o_1,
  output logic [31:0] imm_o_1,
  output logic [2:0]  alu_op_o_1,
  output logic [6:0]  opcode_o_1,
  output logic [5:0]  rs1_o_2,
  output logic [5:0]  rs2_o_2,
  output logic [5:0]  rd_o_2,
  output logic [5:0]  old_rd_o_2,
  output logic [31:0] imm_o_2,
  output logic [2:0]  alu_op_o_2,
  output logic [6:0]  opcode_o_2,
  input  logic        free_valid_1,
  input  logic        free_valid_2,
  input  logic [5:0]  free_preg_1,
  input  logic [5:0]  free_preg_2,
  output logic [5:0]  free_count
);
  localparam int         FL     = NUM_PREGS - NUM_AREGS;
  localparam int         FW     = $clog2(FL);
  localparam logic [5:0] FL_CNT = 6'(FL);

  logic [5:0]    rat [NUM_AREGS];
  logic [5:0]    fl  [FL];
  logic [FW-1:0] head, tail;
  logic [5:0]    count;

  logic          accept, w1, w2, pop1, pop2, ok1, ok2, push_drop;
  logic [FW-1:0] head2;
  logic [5:0]    new1, new2;

  function automatic logic dest_write(input logic [6:0] op, input logic [4:0] rd);
    return (rd != 5'd0) &&
           (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011);
  endfunction

  assign free_count = count;
  assign in_ready   = !full && (count >= 6'd2);
  assign accept     = in_valid && in_ready;
  assign w1         = dest_write(opcode_1, rd_1);
  assign w2         = dest_write(opcode_2, rd_2);
  assign pop1       = accept && w1;
  assign pop2       = accept && w2;
  assign head2      = head + FW'(w1);
  assign new1       = fl[head];
  assign new2       = fl[head2];

  // Capacity is judged on the pre-edge count; same-cycle pops do not make room.
  assign ok1 = free_valid_1 && (free_preg_1 != 6'd0) && (count < FL_CNT);
  assign ok2 = free_valid_2 && (free_preg_2 != 6'd0) && ((count + 6'(ok1)) < FL_CNT);
  assign push_drop = (free_valid_1 && (free_preg_1 != 6'd0) && !ok1) ||
                     (free_valid_2 && (free_preg_2 != 6'd0) && !ok2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREGS; i++) rat[i] <= 6'(i);
      for (int i = 0; i < FL; i++) fl[i] <= 6'(NUM_AREGS + i);
      head  <= '0;
      tail  <= '0;
      count <= FL_CNT;
    end else begin
      if (pop1) rat[rd_1] <= new1;
      // Slot 2 is younger, so its write wins when both target the same rd.
      if (pop2) rat[rd_2] <= new2;
      if (ok1) fl[tail] <= free_preg_1;
      if (ok2) fl[tail + FW'(ok1)] <= free_preg_2;
      head  <= head + FW'(pop1) + FW'(pop2);
      tail  <= tail + FW'(ok1) + FW'(ok2);
      count <= count + 6'(ok1) + 6'(ok2) - 6'(pop1) - 6'(pop2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      rs1_o_1    <= '0;
      rs2_o_1    <= '0;
      rd_o_1     <= '0;
      old_rd_o_1 <= '0;
      imm_o_1    <= '0;
      alu_op_o_1 <= '0;
      opcode_o_1 <= '0;
      rs1_o_2    <= '0;
      rs2_o_2    <= '0;
      rd_o_2     <= '0;
      old_rd_o_2 <= '0;
      imm_o_2    <= '0;
      alu_op_o_2 <= '0;
      opcode_o_2 <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        rs1_o_1    <= rat[rs1_1];
        rs2_o_1    <= rat[rs2_1];
        rd_o_1     <= w1 ? new1 : 6'd0;
        old_rd_o_1 <= w1 ? rat[rd_1] : 6'd0;
        imm_o_1    <= imm_1;
        alu_op_o_1 <= alu_op_1;
        opcode_o_1 <= opcode_1;
        // Slot 2 sees slot 1's fresh mapping; rd_1 is never 0 when w1 is set.
        rs1_o_2    <= (w1 && rs1_2 == rd_1) ? new1 : rat[rs1_2];
        rs2_o_2    <= (w1 && rs2_2 == rd_1) ? new1 : rat[rs2_2];
        rd_o_2     <= w2 ? new2 : 6'd0;
        old_rd_o_2 <= !w2 ? 6'd0 : (w1 && rd_2 == rd_1) ? new1 : rat[rd_2];
        imm_o_2    <= imm_2;
        alu_op_o_2 <= alu_op_2;
        opcode_o_2 <= opcode_2;
      end
    end
  end

  free_list_no_overflow: assert property (@(posedge clk) disable iff (reset) !push_drop);

endmodule

// File: tb/tb_rename_stage.sv
// Randomized and directed bench for rename_stage against a sequential-rename
// reference model (map table array plus free-list queue).
module tb_rename_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, full, out_valid;
  logic [4:0]  rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
  logic [31:0] imm_1, imm_2, imm_o_1, imm_o_2;
  logic [2:0]  alu_op_1, alu_op_2, alu_op_o_1, alu_op_o_2;
  logic [6:0]  opcode_1, opcode_2, opcode_o_1, opcode_o_2;
  logic [5:0]  rs1_o_1, rs2_o_1, rd_o_1, old_rd_o_1;
  logic [5:0]  rs1_o_2, rs2_o_2, rd_o_2, old_rd_o_2;
  logic        free_valid_1, free_valid_2;
  logic [5:0]  free_preg_1, free_preg_2, free_count;

  rename_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .imm_1(imm_1), .alu_op_1(alu_op_1), .opcode_1(opcode_1),
    .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2), .imm_2(imm_2), .alu_op_2(alu_op_2), .opcode_2(opcode_2),
    .full(full), .out_valid(out_valid),
    .rs1_o_1(rs1_o_1), .rs2_o_1(rs2_o_1), .rd_o_1(rd_o_1), .old_rd_o_1(old_rd_o_1),
    .imm_o_1(imm_o_1), .alu_op_o_1(alu_op_o_1), .opcode_o_1(opcode_o_1),
    .rs1_o_2(rs1_o_2), .rs2_o_2(rs2_o_2), .rd_o_2(rd_o_2), .old_rd_o_2(old_rd_o_2),
    .imm_o_2(imm_o_2), .alu_op_o_2(alu_op_o_2), .opcode_o_2(opcode_o_2),
    .free_valid_1(free_valid_1), .free_valid_2(free_valid_2),
    .free_preg_1(free_preg_1), .free_preg_2(free_preg_2), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: slots are renamed one after the other against a map table.
  logic [5:0]  rat_m [32];
  logic [5:0]  fq [$];
  logic [5:0]  pend [$];
  logic        e_valid;
  logic [5:0]  e_rs1 [2], e_rs2 [2], e_rd [2], e_old [2];
  logic [41:0] e_pay [2];
  logic [6:0]  ops [6];

  function automatic bit wr(input logic [6:0] op, input logic [4:0] rd);
    return rd != 5'd0 && (op == 7'h33 || op == 7'h13 || op == 7'h03);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat_m[i] = 6'(i);
    fq.delete();
    for (int i = 32; i < 64; i++) fq.push_back(6'(i));
    pend.delete();
    e_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      e_rs1[s] = '0; e_rs2[s] = '0; e_rd[s] = '0; e_old[s] = '0; e_pay[s] = '0;
    end
  endtask

  task automatic model_edge();
    logic [4:0]  a [2], b [2], d [2];
    logic [6:0]  op [2];
    logic [41:0] pay [2];
    bit acc;
    int pre;
    a[0] = rs1_1; b[0] = rs2_1; d[0] = rd_1; op[0] = opcode_1; pay[0] = {imm_1, alu_op_1, opcode_1};
    a[1] = rs1_2; b[1] = rs2_2; d[1] = rd_2; op[1] = opcode_2; pay[1] = {imm_2, alu_op_2, opcode_2};
    pre = fq.size();
    acc = in_valid && !full && pre >= 2;
    e_valid = acc;
    if (acc) begin
      for (int s = 0; s < 2; s++) begin
        e_rs1[s] = rat_m[a[s]];
        e_rs2[s] = rat_m[b[s]];
        e_pay[s] = pay[s];
        if (wr(op[s], d[s])) begin
          e_rd[s]  = fq.pop_front();
          e_old[s] = rat_m[d[s]];
          rat_m[d[s]] = e_rd[s];
          pend.push_back(e_old[s]);
        end else begin
          e_rd[s] = '0;
          e_old[s] = '0;
        end
      end
    end
    if (free_valid_1 && free_preg_1 != 6'd0 && pre < 32) begin fq.push_back(free_preg_1); pre++; end
    if (free_valid_2 && free_preg_2 != 6'd0 && pre < 32) begin fq.push_back(free_preg_2); pre++; end
  endtask

  task automatic check_outputs();
    chk("out_valid",  64'(out_valid),  64'(e_valid));
    chk("rs1_o_1",    64'(rs1_o_1),    64'(e_rs1[0]));
    chk("rs2_o_1",    64'(rs2_o_1),    64'(e_rs2[0]));
    chk("rd_o_1",     64'(rd_o_1),     64'(e_rd[0]));
    chk("old_rd_o_1", 64'(old_rd_o_1), 64'(e_old[0]));
    chk("payload_1",  64'({imm_o_1, alu_op_o_1, opcode_o_1}), 64'(e_pay[0]));
    chk("rs1_o_2",    64'(rs1_o_2),    64'(e_rs1[1]));
    chk("rs2_o_2",    64'(rs2_o_2),    64'(e_rs2[1]));
    chk("rd_o_2",     64'(rd_o_2),     64'(e_rd[1]));
    chk("old_rd_o_2", 64'(old_rd_o_2), 64'(e_old[1]));
    chk("payload_2",  64'({imm_o_2, alu_op_o_2, opcode_o_2}), 64'(e_pay[1]));
    chk("free_count", 64'(free_count), 64'(fq.size()));
  endtask

  // Called just after a rising edge with the next cycle's inputs already driven.
  task automatic step();
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(!full && fq.size() >= 2));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    in_valid = 0; full = 0;
    free_valid_1 = 0; free_valid_2 = 0; free_preg_1 = '0; free_preg_2 = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input int s, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] a, input logic [4:0] b);
    if (s == 0) begin
      opcode_1 = op; rd_1 = rd; rs1_1 = a; rs2_1 = b; imm_1 = $urandom; alu_op_1 = 3'($urandom);
    end else begin
      opcode_2 = op; rd_2 = rd; rs1_2 = a; rs2_2 = b; imm_2 = $urandom; alu_op_2 = 3'($urandom);
    end
  endtask

  task automatic two_write();
    slot(0, 7'h33, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
    slot(1, 7'h03, 5'($urandom_range(1, 31)), 5'($urandom), 5'($urandom));
  endtask

  task automatic rand_inputs();
    logic [4:0] r1;
    in_valid = ($urandom_range(0, 3) != 0);
    full = ($urandom_range(0, 4) == 0);
    r1 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
    slot(0, ops[$urandom_range(0, 5)], r1, 5'($urandom), 5'($urandom));
    slot(1, ops[$urandom_range(0, 5)],
         ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom),
         ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom),
         ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom));
    if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      free_valid_1 = 1; free_preg_1 = pend.pop_front();
    end else begin
      free_valid_1 = ($urandom_range(0, 7) == 0); free_preg_1 = '0;
    end
    if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
      free_valid_2 = 1; free_preg_2 = pend.pop_front();
    end else begin
      free_valid_2 = ($urandom_range(0, 7) == 0); free_preg_2 = '0;
    end
  endtask

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37};
    reset = 1;
    idle();
    slot(0, 7'h00, 5'd0, 5'd0, 5'd0);
    slot(1, 7'h00, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    chk("rst_count", 64'(free_count), 64'd32);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // add x5 <- x1,x2 ; addi x6 <- x5
    in_valid = 1;
    slot(0, 7'h33, 5'd5, 5'd1, 5'd2);
    slot(1, 7'h13, 5'd6, 5'd5, 5'd0);
    step();
    chk("t1_rs1_1", 64'(rs1_o_1), 64'd1);
    chk("t1_rs2_1", 64'(rs2_o_1), 64'd2);
    chk("t1_rd_1",  64'(rd_o_1), 64'd32);
    chk("t1_old_1", 64'(old_rd_o_1), 64'd5);
    chk("t1_rs1_2", 64'(rs1_o_2), 64'd32);
    chk("t1_rd_2",  64'(rd_o_2), 64'd33);
    chk("t1_old_2", 64'(old_rd_o_2), 64'd6);
    chk("t1_count", 64'(free_count), 64'd30);

    // store ; add to x0 : no allocation
    slot(0, 7'h23, 5'd9, 5'd4, 5'd3);
    slot(1, 7'h33, 5'd0, 5'd1, 5'd1);
    step();
    chk("t2_rd_1", 64'(rd_o_1), 64'd0);
    chk("t2_rd_2", 64'(rd_o_2), 64'd0);
    chk("t2_count", 64'(free_count), 64'd30);
    in_valid = 0;
    step();

    // both slots write x7
    do_reset();
    in_valid = 1;
    slot(0, 7'h33, 5'd7, 5'd1, 5'd2);
    slot(1, 7'h33, 5'd7, 5'd3, 5'd4);
    step();
    chk("t3_rd_1",  64'(rd_o_1), 64'd32);
    chk("t3_rd_2",  64'(rd_o_2), 64'd33);
    chk("t3_old_2", 64'(old_rd_o_2), 64'd32);
    chk("t3_old_1", 64'(old_rd_o_1), 64'd7);
    slot(0, 7'h33, 5'd8, 5'd7, 5'd7);
    slot(1, 7'h13, 5'd0, 5'd0, 5'd0);
    step();
    chk("t3_read_x7", 64'(rs1_o_1), 64'd33);

    // drain the free list, then trickle tags back
    do_reset();
    in_valid = 1;
    repeat (16) begin two_write(); step(); end
    chk("drain_count", 64'(free_count), 64'd0);
    chk("drain_ready", 64'(in_ready), 64'd0);
    free_valid_1 = 1; free_preg_1 = 6'd5;
    step();
    chk("free5_count", 64'(free_count), 64'd1);
    chk("free5_ready", 64'(in_ready), 64'd0);
    free_valid_1 = 0; free_valid_2 = 1; free_preg_2 = 6'd6;
    step();
    chk("free6_ready", 64'(in_ready), 64'd1);
    free_valid_2 = 0;
    two_write();
    step();
    chk("refill_rd_1", 64'(rd_o_1), 64'd5);
    chk("refill_rd_2", 64'(rd_o_2), 64'd6);

    // reservation station full for three cycles
    do_reset();
    in_valid = 1;
    two_write();
    step();
    full = 1;
    repeat (3) begin
      two_write();
      step();
      chk("full_valid", 64'(out_valid), 64'd0);
      chk("full_ready", 64'(in_ready), 64'd0);
      chk("full_count", 64'(free_count), 64'd30);
    end
    full = 0;
    slot(0, 7'h33, 5'd10, 5'd1, 5'd2);
    slot(1, 7'h33, 5'd11, 5'd3, 5'd4);
    step();

    // asynchronous reset in mid-stream
    do_reset();
    in_valid = 1;
    repeat (6) begin two_write(); step(); end
    chk("mid_pre_count", 64'(free_count), 64'd20);
    #2;
    reset = 1;
    #1;
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_rd_1",  64'(rd_o_1), 64'd0);
    chk("mid_count", 64'(free_count), 64'd32);
    do_reset();
    in_valid = 1;
    slot(0, 7'h33, 5'd9, 5'd1, 5'd2);
    slot(1, 7'h13, 5'd0, 5'd0, 5'd0);
    step();
    chk("post_rd_1",  64'(rd_o_1), 64'd32);
    chk("post_old_1", 64'(old_rd_o_1), 64'd9);

    // randomized traffic with commits returning old mappings
    do_reset();
    repeat (400) begin rand_inputs(); step(); end
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
